// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and default sizes for the master, the slave memory and the bench.
package axi_lite_pkg;

  localparam int AXI_ADDR_W    = 32;
  localparam int AXI_DATA_W    = 32;
  localparam int AXI_MEM_DEPTH = 32;
  localparam int AXI_STRB_W    = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Word storage split into byte lanes: byte-strobed sync write, registered read, async clear.
module axi_lite_regfile #(
  parameter  int DEPTH     = 32,
  parameter  int NUM_LANES = 4,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [NUM_LANES-1:0]   wr_strb,
  input  logic [NUM_LANES*8-1:0] wr_data,
  input  logic                   rd_en,
  input  logic                   rd_zero,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [NUM_LANES*8-1:0] rd_data
);

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    logic [DEPTH-1:0][7:0] mem_q, mem_d;
    logic [7:0]            rd_q, rd_d;

    // Read samples mem_q, so a write committing on the same edge is not seen.
    always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      if (we && wr_strb[b]) mem_d[wr_idx] = wr_data[8*b +: 8];
      if (rd_en)            rd_d = rd_zero ? 8'h00 : mem_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q <= '0;
        rd_q  <= '0;
      end else begin
        mem_q <= mem_d;
        rd_q  <= rd_d;
      end
    end

    assign rd_data[8*b +: 8] = rd_q;
  end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed register memory; independent write/read FSMs.
// Define AXI_SLV_ADDR_DECODE_EN to reject out-of-range addresses with SLVERR instead of wrapping.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int MEM_DEPTH  = AXI_MEM_DEPTH
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  resp_t                 rresp_q, rresp_d;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_oor, rd_oor, mem_we, rd_en;

  // A channel arriving in the commit cycle is used straight from the bus.
  assign wr_addr = aw_got_q ? awaddr_q : awaddr;
  assign wr_data = w_got_q  ? wdata_q  : wdata;
  assign wr_strb = w_got_q  ? wstrb_q  : wstrb;

`ifdef AXI_SLV_ADDR_DECODE_EN
  assign wr_oor = |wr_addr[ADDR_WIDTH-1:IDX_W+2];
  assign rd_oor = |araddr[ADDR_WIDTH-1:IDX_W+2];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (awready_q && awvalid) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (wready_q && wvalid) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        awready_d = !aw_got_d;
        wready_d  = !w_got_d;
        if (aw_got_d && w_got_d) begin
          wr_state_d = W_RESP;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          mem_we     = !wr_oor;
          if (wr_oor) bresp_d = SLVERR;
          else        bresp_d = OKAY;
        end
      end
      W_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rd_en      = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && arvalid) begin
          rd_state_d = R_DATA;
          rd_en      = 1'b1;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          if (rd_oor) rresp_d = SLVERR;
          else        rresp_d = OKAY;
        end
      end
      R_DATA: begin
        if (rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  axi_lite_regfile #(.DEPTH(MEM_DEPTH), .NUM_LANES(DATA_WIDTH/8)) u_regfile (
    .clk     (aclk),
    .rst_n   (areset_n),
    .we      (mem_we),
    .wr_idx  (wr_addr[IDX_W+1:2]),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_zero (rd_oor),
    .rd_idx  (araddr[IDX_W+1:2]),
    .rd_data (rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem with a reference memory model and B/R scoreboards.
module tb_axi_lite_slave_mem;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  logic [31:0] model [32];
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  int          passed = 0, total = 0, fails = 0;

  always #5 aclk = ~aclk;

  axi_lite_slave_mem dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_oor(input logic [31:0] a);
`ifdef AXI_SLV_ADDR_DECODE_EN
    return |a[31:7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (addr_oor(a)) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[a[6:2]][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic rexp_t mdl_read(input logic [31:0] a);
    rexp_t e;
    if (addr_oor(a)) begin e.data = 32'h0; e.resp = 2'b10; end
    else             begin e.data = model[a[6:2]]; e.resp = 2'b00; end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the later handshake edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n = 0;
    logic aw_fire, w_fire;
    bq.push_back(mdl_write(a, d, s));
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge aclk); n++;
      if (aw_fire) awvalid = 1'b0;
      if (w_fire)  wvalid  = 1'b0;
    end
    if (n >= 20) begin chk("wr_hs_timeout", 32'd0, 32'd1); awvalid = 1'b0; wvalid = 1'b0; end
    chk("b_latency", {31'd0, bvalid}, 32'd1);
  endtask

  task automatic wait_b();
    int n = 0;
    logic [1:0] e;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) chk("b_timeout", 32'd0, 32'd1);
    e = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
    chk("bresp", {30'd0, bresp}, {30'd0, e});
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("b_done", {30'd0, bvalid, awready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a);
    int  n = 0;
    logic fire;
    rq.push_back(mdl_read(a));
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      fire = arready;
      @(negedge aclk); n++;
      if (fire) arvalid = 1'b0;
    end
    if (n >= 20) begin chk("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; end
    chk("r_latency", {31'd0, rvalid}, 32'd1);
  endtask

  task automatic wait_r();
    int n = 0;
    rexp_t e;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) chk("r_timeout", 32'd0, 32'd1);
    if (rq.size() != 0) e = rq.pop_front();
    else begin e.data = 'x; e.resp = 'x; end
    chk("rdata", rdata, e.data);
    chk("rresp", {30'd0, rresp}, {30'd0, e.resp});
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    chk("r_done", {30'd0, rvalid, arready}, 32'd1);
  endtask

  initial begin
    logic [31:0] hold;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset values
    repeat (3) @(negedge aclk);
    chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_resp",  {28'd0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    areset_n = 1'b1;
    @(negedge aclk);
    chk("idle_ready", {29'd0, awready, wready, arready}, 32'h7);
    chk("idle_valid", {30'd0, bvalid, rvalid}, 32'd0);

    // AW and W together, then read back
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF);
    wait_b();
    do_read(32'h8);
    wait_r();

    // W two cycles ahead of AW
    bq.push_back(mdl_write(32'hC, 32'h0BAD_F00D, 4'hF));
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("w_first_ready", {29'd0, wready, awready, bvalid}, 32'h2);
    @(negedge aclk);
    chk("w_first_nob", {31'd0, bvalid}, 32'd0);
    awaddr = 32'hC; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("aw_late_b", {31'd0, bvalid}, 32'd1);
    wait_b();
    do_read(32'hC);
    wait_r();

    // Byte strobes
    do_write(32'h4, 32'h1122_3344, 4'hF);
    wait_b();
    do_write(32'h4, 32'hAABB_CCDD, 4'b0101);
    wait_b();
    do_read(32'h4);
    chk("strb_merge", rdata, 32'h11BB_33DD);
    wait_r();

    // Backpressure on B and R
    do_write(32'h10, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("b_stall", {29'd0, bvalid, bresp}, 32'h4);
    end
    wait_b();
    do_read(32'h10);
    hold = rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("r_stall_v", {31'd0, rvalid}, 32'd1);
      chk("r_stall_d", rdata, hold);
    end
    wait_r();

    // Address beyond the memory
    do_write(32'h100, 32'h5A5A_5A5A, 4'hF);
    wait_b();
    do_read(32'h0);
    wait_r();
    do_read(32'h100);
    wait_r();

    // Reset with AW captured aborts the write and clears memory
    awaddr = 32'h8; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    areset_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge aclk);
    chk("abort_rst", {28'd0, awready, wready, bvalid, rvalid}, 32'd0);
    areset_n = 1'b1;
    @(negedge aclk);
    do_read(32'h8);
    wait_r();
    chk("abort_nob", {31'd0, bvalid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
# axi_lite_slave_mem

AXI4-Lite slave with a word-addressed register memory; it sits directly downstream of `axi_lite_dut` (the master) and consumes its AW/W/AR channels. It returns B and R responses. Write and read paths are independent FSMs sharing one storage array. It is the bench's reference target for every master transaction.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width; fixed to 32 in this revision, so 4 strobe bits.
- `MEM_DEPTH`, 32: number of 32-bit words; power of two.
- `aclk` in 1: the single clock.
- `areset_n` in 1: asynchronous, active-low reset.
- `awaddr` in ADDR_WIDTH, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in DATA_WIDTH, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_WIDTH, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out DATA_WIDTH, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- Word index is `addr[$clog2(MEM_DEPTH)+1:2]`. Address bits [1:0] are ignored.
- Write FSM states:
  - W_IDLE: `awready` and `wready` are high while their channel is not yet captured. AW and W handshakes are accepted in either order or in the same cycle. Each ready drops on the edge its channel is captured.
  - When both channels are captured, go to W_RESP. On that same edge, memory is written byte-wise per `wstrb`; strobe 0 leaves the byte unchanged.
  - W_RESP: `bvalid`=1 and `bresp` valid. Hold until `bready`. On the B handshake, return to W_IDLE.
- Read FSM states:
  - R_IDLE: `arready`=1. The AR handshake captures the address and registers `rdata`/`rresp`, then goes to R_DATA.
  - R_DATA: `rvalid`=1. `rdata` and `rresp` stay stable until `rready`, then return to R_IDLE.
- Simultaneous write commit and AR capture to the same word on one edge: the read returns the old data.
- Outputs on B/R are stable while valid is high and ready is low (AXI rule).
- Reset mid-transaction aborts it. Captured AW/W are discarded, no B or R is issued, and the memory is cleared.

## Timing
- Reset values:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp` = 2'b00.
  - `rdata` = 0.
  - All memory words = 0.
- Readies rise on the first `aclk` edge after `areset_n` deasserts.
- Write latency: `bvalid` is high the cycle after the later of the AW and W handshakes.
- Read latency: `rvalid` is high the cycle after the AR handshake.
- Back-to-back throughput: with the master ready, a write takes 2 cycles minimum (capture, response), and likewise a read.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `AXI_SLV_ADDR_DECODE_EN`:
  - Defined: an address whose word index is ≥ `MEM_DEPTH`, i.e. any of `addr[ADDR_WIDTH-1:$clog2(MEM_DEPTH)+2]` nonzero, is out of range. Such a write is dropped with `bresp`=SLVERR (2'b10). Such a read returns `rdata`=0 with `rresp`=SLVERR.
  - Undefined: the upper bits are ignored, the address wraps modulo `MEM_DEPTH`, and every response is OKAY (2'b00).

## Structure
- Package `axi_lite_pkg`: `resp_t` enum (OKAY=2'b00, SLVERR=2'b10), `wr_state_t`/`rd_state_t` enums, and default width/depth constants. It is shared with the master and the bench.
- Sub-module `axi_lite_regfile`: storage array with one byte-strobed synchronous write port, one synchronous read port, and async clear on `areset_n`.

## Test plan
- Reset, then idle: all outputs at their reset values during reset. One cycle after release, `awready`=`wready`=`arready`=1 and `bvalid`=`rvalid`=0.
- Write 0x0000_0008 ← 0xDEAD_BEEF (strobe 0xF) with AW/W in the same cycle, then read 0x8. Expect `bvalid` 1 cycle after the handshake with OKAY, and `rdata`=0xDEAD_BEEF with OKAY.
- Send W two cycles before AW: `wready` drops after the W handshake, and B is issued one cycle after the AW handshake.
- Write 0x11223344 to 0x4, then write 0xAABBCCDD with strobe 4'b0101. A read returns 0x11BB33DD.
- Hold `bready`=0 and `rready`=0 for 5 cycles: `bvalid`/`rvalid` stay high and `bresp`/`rdata` are unchanged. Assert ready and the FSMs return to idle the next cycle.
- Write 0x0000_0100 ← 0x5A5A_5A5A with the default depth:
  - With `AXI_SLV_ADDR_DECODE_EN`: `bresp`=2'b10, and word 0 still reads 0.
  - Without it: OKAY, and word 0 reads 0x5A5A_5A5A.
